// File: rtl/soc_system_pio_in_irq.sv
// soc_system_pio_in_irq
//   Avalon-MM input PIO for the lightweight HPS-to-FPGA bridge. Each input bit
//   is synchronised, debounced by a per-bit counter, and edge-detected. Edges
//   of the enabled polarity latch into a write-1-to-clear CAPTURE register.
//   A masked OR of CAPTURE drives a level-sensitive interrupt.
//
// Ports
//   clk, reset_n   system clock; asynchronous active-low reset
//   address[2:0]   word register select
//                    0 DATA, 1 IRQ_MASK, 2 RISE_EN, 3 CAPTURE (W1C),
//                    4 FALL_EN, 5 DEB_THR, 6..7 reserved (read 0)
//   chipselect     slave select (qualifies writes only)
//   write_n        active-low write strobe
//   writedata[31:0] write data
//   in_port[WIDTH-1:0] asynchronous external inputs
//   readdata[31:0] registered read data, one cycle after address
//   irq            level interrupt, high while any unmasked capture bit is set
module soc_system_pio_in_irq #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_W  = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [DEBOUNCE_W-1:0] CNT_ONE = 1;

    logic [WIDTH-1:0]      sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]      sync_d [SYNC_STAGES];
    logic [DEBOUNCE_W-1:0] cnt_q  [WIDTH];
    logic [DEBOUNCE_W-1:0] cnt_d  [WIDTH];
    logic [WIDTH-1:0]      stable_q, stable_d;
    logic [WIDTH-1:0]      stable_prev_q;
    logic [WIDTH-1:0]      mask_q, mask_d;
    logic [WIDTH-1:0]      rise_en_q, rise_en_d;
    logic [WIDTH-1:0]      fall_en_q, fall_en_d;
    logic [WIDTH-1:0]      capture_q, capture_d;
    logic [DEBOUNCE_W-1:0] thr_q, thr_d;
    logic [31:0]           readdata_q, readdata_d;

    logic [WIDTH-1:0]      sync;
    logic [WIDTH-1:0]      set_vec;
    logic [WIDTH-1:0]      clr_vec;
    logic                  wr_en;
    logic                  unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign sync         = sync_q[SYNC_STAGES-1];
    assign unused_wdata = ^writedata;

    // Synchronizer shift chain.
    always_comb begin
        sync_d[0] = in_port;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    // Debounce: a bit commits once it has disagreed with stable for more than
    // DEB_THR consecutive cycles. The compare comes before the increment, so
    // the counter never exceeds the threshold and cannot wrap.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync[i] != stable_q[i]) begin
                if (cnt_q[i] >= thr_q) begin
                    stable_d[i] = sync[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    // Edges are seen one cycle after stable moves, against the delayed copy.
    assign set_vec = (stable_q & ~stable_prev_q & rise_en_q)
                   | (~stable_q & stable_prev_q & fall_en_q);

    // Register writes. A capture set in the same cycle as its clear wins.
    always_comb begin
        mask_d    = mask_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        thr_d     = thr_q;
        clr_vec   = '0;
        if (wr_en) begin
            case (address)
                3'd1:    mask_d    = writedata[WIDTH-1:0];
                3'd2:    rise_en_d = writedata[WIDTH-1:0];
                3'd3:    clr_vec   = writedata[WIDTH-1:0];
                3'd4:    fall_en_d = writedata[WIDTH-1:0];
                3'd5:    thr_d     = writedata[DEBOUNCE_W-1:0];
                default: ;
            endcase
        end
        capture_d = (capture_q & ~clr_vec) | set_vec;
    end

    // Read data is registered every cycle regardless of chipselect.
    always_comb begin
        readdata_d = '0;
        case (address)
            3'd0:    readdata_d = 32'(stable_q);
            3'd1:    readdata_d = 32'(mask_q);
            3'd2:    readdata_d = 32'(rise_en_q);
            3'd3:    readdata_d = 32'(capture_q);
            3'd4:    readdata_d = 32'(fall_en_q);
            3'd5:    readdata_d = 32'(thr_q);
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            stable_q      <= '0;
            stable_prev_q <= '0;
            mask_q        <= '0;
            rise_en_q     <= '1;
            fall_en_q     <= '1;
            capture_q     <= '0;
            thr_q         <= '0;
            readdata_q    <= '0;
        end else begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            mask_q        <= mask_d;
            rise_en_q     <= rise_en_d;
            fall_en_q     <= fall_en_d;
            capture_q     <= capture_d;
            thr_q         <= thr_d;
            readdata_q    <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(capture_q & mask_q);

endmodule

// File: tb/tb_soc_system_pio_in_irq.sv
// Directed bench for soc_system_pio_in_irq with the default parameters
// (WIDTH=16, SYNC_STAGES=2, DEBOUNCE_W=8). Inputs change and outputs are
// sampled 1 ns after each rising clock edge.
module tb_soc_system_pio_in_irq;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [15:0] in_port;
  logic [31:0] readdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  soc_system_pio_in_irq dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    tick();
    d          = readdata;
    chipselect = 1'b0;
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [31:0] v);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = v;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] exp_tbl [8];
    exp_tbl[0] = 32'h0; exp_tbl[1] = 32'h0; exp_tbl[2] = 32'h0000FFFF; exp_tbl[3] = 32'h0;
    exp_tbl[4] = 32'h0000FFFF; exp_tbl[5] = 32'h0; exp_tbl[6] = 32'h0; exp_tbl[7] = 32'h0;

    // reset
    reset_n    = 1'b0;
    address    = 3'd2;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = '0;
    repeat (3) tick();
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_readdata", readdata, 32'h0);
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      read_reg(3'(a), d);
      check($sformatf("reset_reg%0d", a), d, exp_tbl[a]);
    end
    check("reset_irq_after", {31'b0, irq}, 32'h0);

    // THR=0: 0x0005 reaches DATA after 3 edges, CAPTURE one edge later
    write_reg(3'd1, 32'h1);
    in_port = 16'h0005;
    address = 3'd0;
    repeat (3) tick();
    check("data_before_edge3", readdata, 32'h0);
    check("irq_before_capture", {31'b0, irq}, 32'h0);
    tick();
    check("data_after_edge3", readdata, 32'h5);
    check("irq_after_capture", {31'b0, irq}, 32'h1);
    read_reg(3'd3, d);
    check("capture_rise5", d, 32'h5);
    write_reg(3'd3, 32'h1);
    check("irq_after_w1c", {31'b0, irq}, 32'h0);
    read_reg(3'd3, d);
    check("capture_after_w1c", d, 32'h4);

    // fall-only capture on bit1
    write_reg(3'd3, 32'hFFFF);
    write_reg(3'd2, 32'h0);
    write_reg(3'd4, 32'h2);
    in_port = 16'h0007;
    repeat (20) tick();
    read_reg(3'd3, d);
    check("capture_no_rise", d, 32'h0);
    in_port = 16'h0005;
    repeat (6) tick();
    read_reg(3'd3, d);
    check("capture_fall_bit1", d, 32'h2);
    check("irq_held_masked", {31'b0, irq}, 32'h0);
    write_reg(3'd1, 32'h2);
    check("irq_after_unmask", {31'b0, irq}, 32'h1);
    write_reg(3'd3, 32'hFFFF);
    write_reg(3'd1, 32'h0);
    write_reg(3'd2, 32'hFFFF);
    write_reg(3'd4, 32'hFFFF);

    // THR=10: 8-cycle glitch on bit3 is filtered
    write_reg(3'd5, 32'd10);
    in_port = 16'h000D;
    repeat (8) tick();
    in_port = 16'h0005;
    repeat (20) tick();
    read_reg(3'd0, d);
    check("glitch_data", d, 32'h5);
    read_reg(3'd3, d);
    check("glitch_capture", d, 32'h0);

    // held bit3: stable moves on the 13th edge after in_port changes
    in_port = 16'h000D;
    address = 3'd0;
    repeat (13) tick();
    check("held_before_edge13", readdata, 32'h5);
    tick();
    check("held_after_edge13", readdata, 32'hD);
    read_reg(3'd3, d);
    check("held_capture", d, 32'h8);

    // W1C of bit2 on the same edge bit2's fall sets it
    write_reg(3'd5, 32'd0);
    in_port = 16'h0009;
    repeat (3) tick();
    write_reg(3'd3, 32'h4);
    read_reg(3'd3, d);
    check("set_beats_clear", d, 32'hC);

    // lowering the threshold under a running count commits on the next edge
    write_reg(3'd5, 32'd10);
    in_port = 16'h0019;
    repeat (6) tick();
    write_reg(3'd5, 32'd0);
    address = 3'd0;
    tick();
    check("thr_drop_before", readdata, 32'h9);
    tick();
    check("thr_drop_after", readdata, 32'h19);
    read_reg(3'd3, d);
    check("thr_drop_capture", d, 32'h1C);

    // fill CAPTURE, start a count, then reset mid-operation
    in_port = 16'hFFE6;
    repeat (4) tick();
    write_reg(3'd1, 32'hFFFF);
    check("irq_all", {31'b0, irq}, 32'h1);
    read_reg(3'd3, d);
    check("capture_all", d, 32'hFFFF);
    write_reg(3'd5, 32'd10);
    in_port = 16'h0001;
    repeat (5) tick();
    address = 3'd3;
    reset_n = 1'b0;
    #1;
    check("midreset_irq", {31'b0, irq}, 32'h0);
    check("midreset_readdata", readdata, 32'h0);
    repeat (2) tick();
    reset_n = 1'b1;
    // bit0 is held high across release: DATA still 0 on the first reads
    for (int a = 0; a < 8; a++) begin
      read_reg(3'(a), d);
      check($sformatf("postreset_reg%0d", a), d, exp_tbl[a]);
    end
    read_reg(3'd0, d);
    check("postreset_data_rise", d, 32'h1);
    read_reg(3'd3, d);
    check("postreset_capture_rise", d, 32'h1);
    check("postreset_irq", {31'b0, irq}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
